// File: rtl/clownfish_vec_pkg.sv
// Shared vector-issue types and opcode classification.
// Pure declarations and functions, no timing or flow control.
// Not applicable: no handshake lives here.
package clownfish_vec_pkg;

    localparam logic [5:0] OP_VSETVL = 6'h3F;
    localparam logic [5:0] OP_VLOAD  = 6'h20;
    localparam logic [5:0] OP_VSTORE = 6'h21;
    localparam logic [5:0] OP_VX_LO  = 6'h08;
    localparam logic [5:0] OP_VX_HI  = 6'h0B;

    typedef struct packed {
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        logic [31:0] scalar;
        logic [5:0]  op;
        logic [5:0]  rob_id;
        logic [6:0]  phys_dest;
    } vop_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] rob_id;
        logic [4:0] vd;
        logic       writes_vd;
    } infl_t;

    function automatic logic is_vx(input logic [5:0] op);
        return (op >= OP_VX_LO) && (op <= OP_VX_HI);
    endfunction

    function automatic logic reads_vs1(input logic [5:0] op);
        return !((op == OP_VSETVL) || (op == OP_VLOAD) || (op == OP_VSTORE));
    endfunction

    function automatic logic reads_vs2(input logic [5:0] op);
        return !((op == OP_VSETVL) || (op == OP_VLOAD) || is_vx(op));
    endfunction

    function automatic logic writes_vd(input logic [5:0] op);
        return !((op == OP_VSETVL) || (op == OP_VSTORE));
    endfunction

endpackage

// File: rtl/vec_scoreboard.sv
// Busy-vreg vector plus in-flight (rob_id, vd) table for the vector issue path.
// Insert/complete take effect at the next edge; busy/full/empty are registered views.
// No backpressure of its own: the caller must not insert while full.
module vec_scoreboard
    import clownfish_vec_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        ins_vld,
    input  logic [5:0]  ins_rob_id,
    input  logic [4:0]  ins_vd,
    input  logic        ins_writes_vd,
    input  logic        cmpl_vld,
    input  logic [5:0]  cmpl_rob_id,
    output logic [31:0] busy,
    output logic        full,
    output logic        empty
);
    localparam int IDX_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    infl_t             tbl [MAX_INFLIGHT];
    logic [IDX_W-1:0]  alloc_idx;
    logic              alloc_found;
    logic [IDX_W-1:0]  match_idx;
    logic              match_found;
    logic [31:0]       set_vec;
    logic [31:0]       clr_vec;

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        match_idx   = '0;
        match_found = 1'b0;
        full        = 1'b1;
        empty       = 1'b1;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (tbl[i].vld) begin
                empty = 1'b0;
            end else begin
                full = 1'b0;
            end
            if (!tbl[i].vld && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
            if (cmpl_vld && tbl[i].vld && (tbl[i].rob_id == cmpl_rob_id) && !match_found) begin
                match_idx   = IDX_W'(i);
                match_found = 1'b1;
            end
        end
    end

    // Set is OR-ed in after the clear so a same-cycle set of the same vreg wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ins_vld && ins_writes_vd) begin
            set_vec = 32'b1 << ins_vd;
        end
        if (match_found && tbl[match_idx].writes_vd) begin
            clr_vec = 32'b1 << tbl[match_idx].vd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tbl[i] <= '0;
            end
        end else if (flush_i) begin
            busy <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
            if (match_found) begin
                tbl[match_idx].vld <= 1'b0;
            end
            if (ins_vld && alloc_found) begin
                tbl[alloc_idx] <= '{vld: 1'b1, rob_id: ins_rob_id, vd: ins_vd, writes_vd: ins_writes_vd};
            end
        end
    end

endmodule

// File: rtl/vector_issue_scheduler.sv
// In-order vector issue: dispatch FIFO + hazard-checked head issue into vector_unit.
// Zero added issue latency: head issues combinationally in the cycle it is hazard-free.
// disp_ready_o drops when the FIFO is full; head holds while vu_ready_i=0 or hazarded.
module vector_issue_scheduler
    import clownfish_vec_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_valid_i,
    output logic        disp_ready_o,
    input  logic [4:0]  disp_vs1_i,
    input  logic [4:0]  disp_vs2_i,
    input  logic [4:0]  disp_vd_i,
    input  logic [31:0] disp_scalar_i,
    input  logic [5:0]  disp_op_i,
    input  logic [5:0]  disp_rob_id_i,
    input  logic [6:0]  disp_phys_dest_i,
    output logic        iss_valid_o,
    output logic [4:0]  iss_vs1_o,
    output logic [4:0]  iss_vs2_o,
    output logic [4:0]  iss_vd_o,
    output logic [31:0] iss_scalar_o,
    output logic [5:0]  iss_op_o,
    output logic [5:0]  iss_rob_id_o,
    output logic [6:0]  iss_phys_dest_o,
    input  logic        vu_ready_i,
    input  logic        cmpl_valid_i,
    input  logic [5:0]  cmpl_rob_id_i,
    input  logic        flush_i,
    output logic        hazard_stall_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    vop_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    vop_t              head;
    logic              head_vld;
    logic              push;
    logic              is_vsetvl;
    logic              hazard;
    logic [31:0]       busy;
    logic              sb_full;
    logic              sb_empty;

    assign head         = fifo_mem[rd_ptr];
    assign head_vld     = (count != '0);
    assign disp_ready_o = (count < CNT_W'(DEPTH));
    assign push         = disp_valid_i && disp_ready_o && !flush_i;
    assign is_vsetvl    = (head.op == OP_VSETVL);

    always_comb begin
        hazard = 1'b0;
        if (reads_vs1(head.op) && busy[head.vs1]) hazard = 1'b1;
        if (reads_vs2(head.op) && busy[head.vs2]) hazard = 1'b1;
        if (writes_vd(head.op) && busy[head.vd])  hazard = 1'b1;
        // VSETVL changes vl/vtype under every older op, so it waits for a drained table.
        if (is_vsetvl && !sb_empty)               hazard = 1'b1;
    end

    assign iss_valid_o    = head_vld && vu_ready_i && !flush_i && !hazard && !sb_full;
    assign hazard_stall_o = head_vld && vu_ready_i && !iss_valid_o && !flush_i;

    assign iss_vs1_o       = head.vs1;
    assign iss_vs2_o       = head.vs2;
    assign iss_vd_o        = head.vd;
    assign iss_scalar_o    = head.scalar;
    assign iss_op_o        = head.op;
    assign iss_rob_id_o    = head.rob_id;
    assign iss_phys_dest_o = head.phys_dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{vs1: disp_vs1_i, vs2: disp_vs2_i, vd: disp_vd_i,
                                      scalar: disp_scalar_i, op: disp_op_i,
                                      rob_id: disp_rob_id_i, phys_dest: disp_phys_dest_i};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (iss_valid_o) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(iss_valid_o);
        end
    end

    vec_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .ins_vld       (iss_valid_o && !is_vsetvl),
        .ins_rob_id    (head.rob_id),
        .ins_vd        (head.vd),
        .ins_writes_vd (writes_vd(head.op)),
        .cmpl_vld      (cmpl_valid_i),
        .cmpl_rob_id   (cmpl_rob_id_i),
        .busy          (busy),
        .full          (sb_full),
        .empty         (sb_empty)
    );

endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Scoreboard bench for vector_issue_scheduler: accepted dispatches are queued as expected issues
// and matched in order against the issue port; directed checks cover hazards, VSETVL, full FIFO and flush.
module tb_vector_issue_scheduler;

    localparam logic [5:0] OP_VADD   = 6'h00;
    localparam logic [5:0] OP_VSUB   = 6'h01;
    localparam logic [5:0] OP_VADDVX = 6'h08;
    localparam logic [5:0] OP_VLOAD  = 6'h20;
    localparam logic [5:0] OP_VSETVL = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [4:0]  disp_vs1_i, disp_vs2_i, disp_vd_i;
    logic [31:0] disp_scalar_i;
    logic [5:0]  disp_op_i, disp_rob_id_i;
    logic [6:0]  disp_phys_dest_i;
    logic        iss_valid_o;
    logic [4:0]  iss_vs1_o, iss_vs2_o, iss_vd_o;
    logic [31:0] iss_scalar_o;
    logic [5:0]  iss_op_o, iss_rob_id_o;
    logic [6:0]  iss_phys_dest_o;
    logic        vu_ready_i;
    logic        cmpl_valid_i;
    logic [5:0]  cmpl_rob_id_i;
    logic        flush_i;
    logic        hazard_stall_o;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_issued = 0;
    logic [65:0] exp_q [$];

    always #5 clk = ~clk;

    vector_issue_scheduler #(.DEPTH(4), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_vs1_i(disp_vs1_i), .disp_vs2_i(disp_vs2_i), .disp_vd_i(disp_vd_i),
        .disp_scalar_i(disp_scalar_i), .disp_op_i(disp_op_i),
        .disp_rob_id_i(disp_rob_id_i), .disp_phys_dest_i(disp_phys_dest_i),
        .iss_valid_o(iss_valid_o), .iss_vs1_o(iss_vs1_o), .iss_vs2_o(iss_vs2_o),
        .iss_vd_o(iss_vd_o), .iss_scalar_o(iss_scalar_o), .iss_op_o(iss_op_o),
        .iss_rob_id_o(iss_rob_id_o), .iss_phys_dest_o(iss_phys_dest_o),
        .vu_ready_i(vu_ready_i), .cmpl_valid_i(cmpl_valid_i), .cmpl_rob_id_i(cmpl_rob_id_i),
        .flush_i(flush_i), .hazard_stall_o(hazard_stall_o)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor at the falling edge: inputs were driven 1ns after the rising edge and are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("disp_ready_model", {95'b0, disp_ready_o}, {95'b0, exp_q.size() < 4});
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (iss_valid_o) begin
                    n_issued++;
                    if (exp_q.size() == 0) begin
                        chk("iss_unexpected", 96'd1, 96'd0);
                    end else begin
                        chk("iss_fields", {30'b0, iss_vs1_o, iss_vs2_o, iss_vd_o, iss_scalar_o,
                                           iss_op_o, iss_rob_id_o, iss_phys_dest_o},
                            {30'b0, exp_q.pop_front()});
                    end
                end
                if (disp_valid_i && disp_ready_o) begin
                    exp_q.push_back({disp_vs1_i, disp_vs2_i, disp_vd_i, disp_scalar_i,
                                     disp_op_i, disp_rob_id_i, disp_phys_dest_i});
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic push(input logic [5:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [5:0] rob);
        disp_valid_i     = 1'b1;
        disp_op_i        = op;
        disp_vd_i        = vd;
        disp_vs1_i       = vs1;
        disp_vs2_i       = vs2;
        disp_rob_id_i    = rob;
        disp_scalar_i    = 32'hA5A5_0000 ^ {26'b0, rob};
        disp_phys_dest_i = {1'b1, rob};
    endtask

    task automatic cmpl(input logic [5:0] rob);
        cmpl_valid_i  = 1'b1;
        cmpl_rob_id_i = rob;
    endtask

    task automatic wait_iss(input logic [5:0] rob, input int budget);
        for (int k = 0; k < budget; k++) begin
            smp();
            if (iss_valid_o) begin
                chk("drain_order", {90'b0, iss_rob_id_o}, {90'b0, rob});
                nxt();
                return;
            end
            nxt();
        end
        chk("issue_timeout", 96'd0, 96'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; disp_valid_i = 1'b0; vu_ready_i = 1'b0; cmpl_valid_i = 1'b0;
        cmpl_rob_id_i = '0; flush_i = 1'b0;
        push(OP_VADD, 0, 0, 0, 0);
        disp_valid_i = 1'b0;
        #3;
        chk("rst_disp_ready", {95'b0, disp_ready_o}, 96'd1);
        chk("rst_iss_valid", {95'b0, iss_valid_o}, 96'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
        chk("rst_hazard", {95'b0, hazard_stall_o}, 96'd0);
        chk("rst_iss_fields", {29'b0, iss_vd_o, iss_rob_id_o, iss_scalar_o, iss_op_o}, 96'd0);
        vu_ready_i = 1'b1;

        // Single op issues the cycle after it is pushed.
        nxt();
        push(OP_VADD, 3, 1, 2, 1);
        smp(); chk("t1_no_bypass", {95'b0, iss_valid_o}, 96'd0);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t1_issue", {95'b0, iss_valid_o}, 96'd1);
        chk("t1_vd", {91'b0, iss_vd_o}, 96'd3);
        nxt(); cmpl(1);
        nxt(); cmpl_valid_i = 1'b0;

        // RAW: VSUB reading v5 waits for VADD(v5) completion plus one bubble.
        push(OP_VADD, 5, 1, 2, 2);
        nxt(); push(OP_VSUB, 8, 5, 6, 3);
        smp(); chk("t2_vadd_issue", {95'b0, iss_valid_o}, 96'd1);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t2_raw_block", {95'b0, iss_valid_o}, 96'd0);
        chk("t2_raw_stall", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl(2);
        smp(); chk("t2_cmpl_bubble", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl_valid_i = 1'b0;
        smp(); chk("t2_vsub_issue", {95'b0, iss_valid_o}, 96'd1);
        chk("t2_vsub_rob", {90'b0, iss_rob_id_o}, 96'd3);
        nxt();

        // VSETVL waits for an empty in-flight table (rob 3 and rob 4 outstanding).
        push(OP_VLOAD, 9, 0, 0, 4);
        nxt(); push(OP_VSETVL, 0, 0, 0, 5);
        smp(); chk("t3_vload_issue", {95'b0, iss_valid_o}, 96'd1);
        nxt(); disp_valid_i = 1'b0; cmpl(3);
        smp(); chk("t3_hold_two", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl(4);
        smp(); chk("t3_hold_one", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl_valid_i = 1'b0;
        smp(); chk("t3_vsetvl_issue", {95'b0, iss_valid_o}, 96'd1);
        chk("t3_vsetvl_op", {90'b0, iss_op_o}, {90'b0, OP_VSETVL});
        nxt(); push(OP_VSETVL, 0, 0, 0, 7);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t3_table_still_empty", {95'b0, iss_valid_o}, 96'd1);
        nxt(); push(OP_VADD, 10, 8, 9, 6);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t3_sb_clear", {95'b0, iss_valid_o}, 96'd1);
        nxt(); cmpl(6);
        nxt(); cmpl_valid_i = 1'b0;

        // Full FIFO with vu_ready_i low, 5th push refused, drain in order.
        vu_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(OP_VADDVX, 5'(11 + i), 1, 0, 6'(10 + i));
            nxt();
        end
        push(OP_VADD, 20, 1, 2, 14);
        smp(); chk("t4_full", {95'b0, disp_ready_o}, 96'd0);
        chk("t4_no_stall_vu_busy", {95'b0, hazard_stall_o}, 96'd0);
        nxt(); disp_valid_i = 1'b0; vu_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_iss(6'(10 + i), 4);
        end
        smp(); chk("t4_drained", {95'b0, disp_ready_o}, 96'd1);
        push(OP_VLOAD, 20, 0, 0, 15);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t4_inflight_full", {95'b0, iss_valid_o}, 96'd0);
        chk("t4_full_stall", {95'b0, hazard_stall_o}, 96'd1);
        cmpl(10);
        nxt(); cmpl_valid_i = 1'b0;
        smp(); chk("t4_after_free", {95'b0, iss_valid_o}, 96'd1);
        nxt(); cmpl(11);
        nxt(); cmpl(12);
        nxt(); cmpl(13);
        nxt(); cmpl(15);
        nxt(); cmpl_valid_i = 1'b0;

        // Flush with 3 queued and 2 in flight; same-cycle push dropped, late completions ignored.
        push(OP_VLOAD, 21, 0, 0, 20);
        nxt(); push(OP_VLOAD, 22, 0, 0, 21);
        nxt(); disp_valid_i = 1'b0;
        nxt(); vu_ready_i = 1'b0;
        push(OP_VADD, 23, 21, 2, 22);
        nxt(); push(OP_VADD, 24, 1, 2, 23);
        nxt(); push(OP_VADD, 25, 1, 2, 24);
        nxt(); push(OP_VADD, 26, 1, 2, 25); flush_i = 1'b1; vu_ready_i = 1'b1;
        smp(); chk("t5_flush_no_issue", {95'b0, iss_valid_o}, 96'd0);
        chk("t5_flush_no_stall", {95'b0, hazard_stall_o}, 96'd0);
        nxt(); flush_i = 1'b0; disp_valid_i = 1'b0; cmpl(20);
        smp(); chk("t5_fifo_empty", {95'b0, iss_valid_o}, 96'd0);
        chk("t5_ready", {95'b0, disp_ready_o}, 96'd1);
        nxt(); push(OP_VADD, 21, 21, 22, 26); cmpl(21);
        nxt(); disp_valid_i = 1'b0; cmpl_valid_i = 1'b0;
        smp(); chk("t5_sb_cleared", {95'b0, iss_valid_o}, 96'd1);
        chk("t5_rob", {90'b0, iss_rob_id_o}, 96'd26);
        nxt(); cmpl(26);
        nxt(); cmpl_valid_i = 1'b0;

        // v7 freed then re-set by the next writer; a reader of v7 must block again.
        push(OP_VLOAD, 7, 0, 0, 30);
        nxt(); push(OP_VADD, 7, 1, 2, 31);
        smp(); chk("t6_vload_issue", {95'b0, iss_valid_o}, 96'd1);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t6_waw_stall", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl(30);
        smp(); chk("t6_bubble", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl_valid_i = 1'b0;
        smp(); chk("t6_writer_issue", {95'b0, iss_valid_o}, 96'd1);
        chk("t6_writer_rob", {90'b0, iss_rob_id_o}, 96'd31);
        push(OP_VADDVX, 12, 7, 0, 32);
        nxt(); disp_valid_i = 1'b0;
        smp(); chk("t6_set_wins_stall", {95'b0, hazard_stall_o}, 96'd1);
        nxt(); cmpl(31);
        nxt(); cmpl_valid_i = 1'b0;
        smp(); chk("t6_reader_issue", {95'b0, iss_valid_o}, 96'd1);
        nxt(); cmpl(32);
        nxt(); cmpl_valid_i = 1'b0;

        repeat (2) nxt();
        chk("queue_drained", {64'b0, 32'(exp_q.size())}, 96'd0);
        chk("issue_count", {64'b0, 32'(n_issued)}, 96'd18);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
